// File: rtl/misr_compactor.sv
// misr_compactor: Galois MISR that folds a fixed number of CUT responses into a
// signature and presents it frozen with a valid flag until the next session.
module misr_compactor #(
  parameter int               WIDTH        = 3,
  parameter int               NUM_PATTERNS = 7,
  parameter logic [WIDTH-1:0] SEED         = '0,
  parameter logic [WIDTH-1:0] POLY         = 3'b011,
  localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cut_valid_i,
  input  logic [WIDTH-1:0] cut_out_i,
  output logic [WIDTH-1:0] sig_o,
  output logic             sig_valid_o,
  output logic             busy_o,
  output logic [CW-1:0]    pat_cnt_o
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q;
  logic             valid_q, busy_q;
  logic             last;
  always_comb begin
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ cut_out_i;
    last  = cnt_q == CW'(NUM_PATTERNS - 1);
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE:
          if (start_i) begin
            state_q <= CAPTURE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        CAPTURE:
          if (cut_valid_i) begin
            sig_q <= sig_d;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  assign sig_o       = sig_q;
  assign sig_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign pat_cnt_o   = cnt_q;
endmodule

// File: tb/tb_misr_compactor.sv
// tb_misr_compactor: bench that checks the compactor every cycle against a
// polynomial-arithmetic model, plus hand-computed signature literals.
module tb_misr_compactor;
  logic       clk_i = 0;
  logic       reset_ni = 0;
  logic       start_i = 0, abort_i = 0, cut_valid_i = 0;
  logic [2:0] cut_out_i = 0;
  logic [2:0] sig_o;
  logic       sig_valid_o, busy_o;
  logic [2:0] pat_cnt_o;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  misr_compactor dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .abort_i(abort_i),
    .cut_valid_i(cut_valid_i), .cut_out_i(cut_out_i), .sig_o(sig_o),
    .sig_valid_o(sig_valid_o), .busy_o(busy_o), .pat_cnt_o(pat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // model: session mode plus the list of responses captured so far
  int         m_st = 0;
  logic [2:0] cap[$];

  // signature = sum over captures of r_i * x^(n-1-i), reduced mod x^3+x+1
  function automatic logic [2:0] fold();
    int s = 0;
    foreach (cap[i]) begin
      s = s * 2;
      if (s >= 8) s = s ^ 'hB;
      s = s ^ int'(cap[i]);
    end
    return s[2:0];
  endfunction

  always @(posedge clk_i or negedge reset_ni)
    if (!reset_ni || abort_i) begin
      m_st = 0;
      cap.delete();
    end else if (m_st != 1 && start_i) begin
      m_st = 1;
      cap.delete();
    end else if (m_st == 1 && cut_valid_i) begin
      cap.push_back(cut_out_i);
      if (cap.size() == 7) m_st = 2;
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk_i) begin
    #1;
    if (chk_en) begin
      chk("model_sig", sig_o, fold());
      chk("model_valid", sig_valid_o, m_st == 2);
      chk("model_busy", busy_o, m_st == 1);
      chk("model_cnt", pat_cnt_o, cap.size());
    end
  end

  task automatic cyc(input logic st, input logic ab, input logic cv, input logic [2:0] co);
    @(negedge clk_i);
    start_i = st; abort_i = ab; cut_valid_i = cv; cut_out_i = co;
    @(posedge clk_i);
    #2;
  endtask

  task automatic golden_stream(input bit gaps);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (gaps)
        repeat ($urandom_range(1, 3)) begin
          cyc(0, 0, 0, 3'b111);
          chk("gap_busy", busy_o, 1);
          chk("gap_valid", sig_valid_o, 0);
        end
      cyc(0, 0, 1, i == 0 ? 3'b100 : 3'b000);
    end
    chk("golden_sig", sig_o, 3'b010);
    chk("golden_valid", sig_valid_o, 1);
  endtask

  logic [2:0] seq1 [7] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b010, 3'b101, 3'b000};
  logic [2:0] seq2 [6] = '{3'b100, 3'b011, 3'b110, 3'b111, 3'b101, 3'b001};

  initial begin
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_sig", sig_o, 0);
    chk("rst_valid", sig_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", pat_cnt_o, 0);
    @(negedge clk_i);
    reset_ni = 1;
    chk_en = 1;
    cyc(0, 0, 1, 3'b101);
    chk("idle_ignores_cut", sig_o, 0);
    cyc(1, 0, 0, 0);
    chk("start_busy", busy_o, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, 3'b001);
      chk($sformatf("seq1_%0d", i), sig_o, seq1[i]);
    end
    chk("seq1_valid", sig_valid_o, 1);
    chk("seq1_cnt", pat_cnt_o, 7);
    chk("seq1_busy", busy_o, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, i == 0 ? 3'b100 : 3'b000);
      if (i < 6) chk($sformatf("seq2_%0d", i), sig_o, seq2[i]);
    end
    chk("seq2_final", sig_o, 3'b010);
    golden_stream(1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, i[0], 3'(i + 3));
      chk("done_frozen", sig_o, 3'b010);
    end
    cyc(1, 0, 1, 3'b111);
    chk("restart_valid", sig_valid_o, 0);
    chk("restart_sig", sig_o, 0);
    chk("restart_cnt", pat_cnt_o, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 3'b110);
    chk("pre_abort_cnt", pat_cnt_o, 4);
    cyc(0, 1, 1, 3'b110);
    chk("abort_sig", sig_o, 0);
    chk("abort_cnt", pat_cnt_o, 0);
    chk("abort_busy", busy_o, 0);
    cyc(1, 1, 0, 0);
    chk("start_abort_busy", busy_o, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3'b011);
    chk_en = 0;
    @(negedge clk_i);
    #2 reset_ni = 0;
    #1;
    chk("async_sig", sig_o, 0);
    chk("async_busy", busy_o, 0);
    chk("async_cnt", pat_cnt_o, 0);
    chk("async_valid", sig_valid_o, 0);
    @(negedge clk_i);
    reset_ni = 1;
    chk_en = 1;
    golden_stream(0);
    chk("final_cnt", pat_cnt_o, 7);
    cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
